// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin_sel / refill_sel
// denomination codes, error codes, FSM state encodings and a helper that
// maps a denomination code onto its coin value.
package change_dispenser_pkg;

    // Denomination codes, largest coin first so index order is greedy order
    localparam logic [1:0] SEL_50 = 2'd0;
    localparam logic [1:0] SEL_10 = 2'd1;
    localparam logic [1:0] SEL_5  = 2'd2;
    localparam logic [1:0] SEL_1  = 2'd3;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_UNDERPAY = 2'd1;
    localparam logic [1:0] ERR_SHORT    = 2'd2;
    localparam logic [1:0] ERR_JAM      = 2'd3;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CALC     = 3'd1;
    localparam logic [2:0] ST_SELECT   = 3'd2;
    localparam logic [2:0] ST_DISPENSE = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

    // Coin value of a denomination code
    function automatic logic [31:0] denom_value(input logic [1:0] sel);
        logic [31:0] val;
        case (sel)
            SEL_50:  val = 32'd50;
            SEL_10:  val = 32'd10;
            SEL_5:   val = 32'd5;
            SEL_1:   val = 32'd1;
            default: val = 32'd1;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_inventory.sv
// Coin inventory: four saturating counters, one per denomination.
// Ports:
//   clk, reset        clock and synchronous active-high reset (counts -> INIT_CNT)
//   refill_i          add refill_cnt_i coins to denomination refill_sel_i (saturating)
//   refill_sel_i      denomination code of the refill
//   refill_cnt_i      number of coins to add
//   dec_i             remove one coin of denomination dec_sel_i
//   dec_sel_i         denomination code of the removed coin
//   nonzero_o         per-denomination "at least one coin in stock" flags
module change_dispenser_coin_inventory
    import change_dispenser_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int INIT_CNT = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refill_i,
    input  logic [1:0]       refill_sel_i,
    input  logic [CNT_W-1:0] refill_cnt_i,
    input  logic             dec_i,
    input  logic [1:0]       dec_sel_i,
    output logic [3:0]       nonzero_o
);

    logic [3:0][CNT_W-1:0] count_q;
    logic [3:0][CNT_W-1:0] count_d;

    // Add with clamp at the all-ones maximum instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Next-state of each counter; decrement is guarded so an empty slot never wraps
    always_comb begin
        count_d = count_q;
        for (int i = 0; i < 4; i++) begin
            if (dec_i && (dec_sel_i == 2'(i)) && (count_q[i] != {CNT_W{1'b0}})) begin
                count_d[i] = count_q[i] - {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (refill_i && (refill_sel_i == 2'(i))) begin
                count_d[i] = sat_add(count_q[i], refill_cnt_i);
            end else begin
                count_d[i] = count_q[i];
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {4{CNT_W'(INIT_CNT)}};
        end else begin
            count_q <= count_d;
        end
    end

    // Stock flags feed the greedy selector
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nonzero_o[i] = (count_q[i] != {CNT_W{1'b0}});
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: computes change (total_money - cost) and pays it out one
// coin at a time to a hopper over a valid/ack handshake, greedy 50/10/5/1.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 accept total_money/cost (IDLE only)
//   total_money, cost     32-bit unsigned amounts
//   coin_ack              hopper took the offered coin
//   err_clr               leave ERROR back to IDLE
//   refill, refill_sel,   add refill_cnt coins of one denomination (IDLE only)
//   refill_cnt
//   busy                  high outside IDLE
//   coin_valid, coin_sel  coin offered to the hopper and its denomination
//   change_left           change still owed
//   done                  one-cycle pulse when the change is fully paid
//   err, err_code         error state flag and cause (held until err_clr)
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int INIT_CNT = 20,
    parameter int ACK_TO   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      total_money,
    input  logic [31:0]      cost,
    input  logic             coin_ack,
    input  logic             err_clr,
    input  logic             refill,
    input  logic [1:0]       refill_sel,
    input  logic [CNT_W-1:0] refill_cnt,
    output logic             busy,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    output logic [31:0]      change_left,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int TO_W = $clog2(ACK_TO + 1);

    logic [2:0]      state_q, state_d;
    logic [31:0]     total_q, total_d;
    logic [31:0]     cost_q, cost_d;
    logic [31:0]     change_q, change_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            busy_q, valid_q, done_q, err_q;

    logic [3:0]      nonzero_s;
    logic            pick_ok_s;
    logic [1:0]      pick_sel_s;
    logic            dec_s;
    logic            refill_ok_s;

    // Refills only land while idle
    assign refill_ok_s = refill && (state_q == ST_IDLE);

    change_dispenser_coin_inventory #(
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT)
    ) u_inv (
        .clk          (clk),
        .reset        (reset),
        .refill_i     (refill_ok_s),
        .refill_sel_i (refill_sel),
        .refill_cnt_i (refill_cnt),
        .dec_i        (dec_s),
        .dec_sel_i    (sel_q),
        .nonzero_o    (nonzero_s)
    );

    // Greedy pick: scan small to large so the largest eligible coin wins
    always_comb begin
        pick_ok_s  = 1'b0;
        pick_sel_s = SEL_1;
        for (int i = 3; i >= 0; i--) begin
            if (nonzero_s[i] && (denom_value(2'(i)) <= change_q)) begin
                pick_ok_s  = 1'b1;
                pick_sel_s = 2'(i);
            end else begin
                pick_ok_s  = pick_ok_s;
            end
        end
    end

    // FSM next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        cost_d     = cost_q;
        change_d   = change_q;
        sel_d      = sel_q;
        err_code_d = err_code_q;
        to_d       = to_q;
        dec_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    total_d = total_money;
                    cost_d  = cost;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (total_q < cost_q) begin
                    change_d   = 32'd0;
                    err_code_d = ERR_UNDERPAY;
                    state_d    = ST_ERROR;
                end else begin
                    change_d = total_q - cost_q;
                    state_d  = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (change_q == 32'd0) begin
                    state_d = ST_DONE;
                end else if (pick_ok_s) begin
                    sel_d   = pick_sel_s;
                    to_d    = {TO_W{1'b0}};
                    state_d = ST_DISPENSE;
                end else begin
                    // Remainder stays visible on change_left as the unpaid amount
                    err_code_d = ERR_SHORT;
                    state_d    = ST_ERROR;
                end
            end
            ST_DISPENSE: begin
                if (coin_ack) begin
                    dec_s    = 1'b1;
                    change_d = change_q - denom_value(sel_q);
                    state_d  = ST_SELECT;
                end else if (to_q == TO_W'(ACK_TO - 1)) begin
                    // Coin offered for ACK_TO cycles with no taker: hopper jammed
                    err_code_d = ERR_JAM;
                    state_d    = ST_ERROR;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (err_clr) begin
                    err_code_d = ERR_NONE;
                    change_d   = 32'd0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            total_q    <= 32'd0;
            cost_q     <= 32'd0;
            change_q   <= 32'd0;
            sel_q      <= 2'd0;
            err_code_q <= ERR_NONE;
            to_q       <= {TO_W{1'b0}};
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            cost_q     <= cost_d;
            change_q   <= change_d;
            sel_q      <= sel_d;
            err_code_q <= err_code_d;
            to_q       <= to_d;
            busy_q     <= (state_d != ST_IDLE);
            valid_q    <= (state_d == ST_DISPENSE);
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERROR);
        end
    end

    assign busy        = busy_q;
    assign coin_valid  = valid_q;
    assign coin_sel    = sel_q;
    assign change_left = change_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a greedy reference model pushes
// the expected coin sequence into a queue at start; the hopper process pops
// and compares each offered coin, and each scenario task checks end status.
module tb_change_dispenser;

    localparam int CNT_W    = 8;
    localparam int INIT_CNT = 20;
    localparam int ACK_TO   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      total_money;
    logic [31:0]      cost;
    logic             coin_ack;
    logic             err_clr;
    logic             refill;
    logic [1:0]       refill_sel;
    logic [CNT_W-1:0] refill_cnt;
    logic             busy;
    logic             coin_valid;
    logic [1:0]       coin_sel;
    logic [31:0]      change_left;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int         m_cnt [4];
    int         dval  [4] = '{50, 10, 5, 1};
    logic [1:0] exp_q [$];
    int         exp_code;
    int         exp_left;

    // Observations captured at the end of a transaction
    logic       got_done, got_err;
    logic [1:0] got_code;
    logic [31:0] got_left;
    int         got_lat;

    change_dispenser #(
        .CNT_W    (CNT_W),
        .INIT_CNT (INIT_CNT),
        .ACK_TO   (ACK_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .total_money (total_money),
        .cost        (cost),
        .coin_ack    (coin_ack),
        .err_clr     (err_clr),
        .refill      (refill),
        .refill_sel  (refill_sel),
        .refill_cnt  (refill_cnt),
        .busy        (busy),
        .coin_valid  (coin_valid),
        .coin_sel    (coin_sel),
        .change_left (change_left),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Greedy reference: expected coins, inventory effect and final status
    task automatic model_txn(input int total, input int cst);
        int rem;
        int k;
        exp_q.delete();
        if (total < cst) begin
            exp_code = 1;
            exp_left = 0;
            return;
        end
        rem = total - cst;
        while (rem > 0) begin
            k = -1;
            for (int i = 0; i < 4; i++) begin
                if (k < 0 && m_cnt[i] > 0 && dval[i] <= rem) k = i;
            end
            if (k < 0) break;
            exp_q.push_back(2'(k));
            m_cnt[k] = m_cnt[k] - 1;
            rem = rem - dval[k];
        end
        exp_left = rem;
        exp_code = (rem == 0) ? 0 : 2;
    endtask

    // Drive one transaction, act as hopper and score each offered coin
    task automatic run_txn(input int total, input int cst, input int ack_delay);
        int cyc;
        int vcnt;
        bit fin;
        logic [1:0] e;
        model_txn(total, cst);
        total_money = 32'(total);
        cost        = 32'(cst);
        start       = 1'b1;
        tick();
        start  = 1'b0;
        refill = 1'b0;
        cyc = 0; vcnt = 0; fin = 1'b0;
        while (!fin && cyc < 3000) begin
            if (done || err) begin
                fin = 1'b1;
            end else if (coin_valid) begin
                if (vcnt == ack_delay) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_coin: got coin_sel=%0d, none expected", coin_sel);
                    end else begin
                        e = exp_q.pop_front();
                        if (coin_sel !== e) begin
                            n_err++;
                            $display("FAIL coin_order: got coin_sel=%0d want %0d", coin_sel, e);
                        end
                    end
                    coin_ack = 1'b1;
                    vcnt = 0;
                end else begin
                    vcnt++;
                end
            end
            if (!fin) begin
                tick();
                coin_ack = 1'b0;
                cyc++;
            end
        end
        got_lat  = cyc + 1;
        got_done = done;
        got_err  = err;
        got_code = err_code;
        got_left = change_left;
        n_cmp++;
        if (!fin) begin
            n_err++;
            $display("FAIL txn_timeout: total=%0d cost=%0d no done/err", total, cst);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_coins: %0d expected coins never offered", exp_q.size());
        end
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; coin_ack = 1'b0; err_clr = 1'b0;
        refill = 1'b0; refill_sel = 2'd0; refill_cnt = '0;
        total_money = 32'd0; cost = 32'd0;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = INIT_CNT;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0 || err_code !== 2'd0 || change_left !== 32'd0) begin
            n_err++;
            $display("FAIL err_clr: got err=%0b busy=%0b code=%0d left=%0d want 0/0/0/0",
                     err, busy, err_code, change_left);
        end
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (int'(dut.u_inv.count_q[i]) != m_cnt[i]) begin
                n_err++;
                $display("FAIL %s_count%0d: got %0d want %0d", tag, i,
                         dut.u_inv.count_q[i], m_cnt[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (busy !== 1'b0 || coin_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            coin_sel !== 2'd0 || change_left !== 32'd0 || err_code !== 2'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%0b valid=%0b done=%0b err=%0b sel=%0d left=%0d code=%0d want all 0",
                     busy, coin_valid, done, err, coin_sel, change_left, err_code);
        end
        check_counts("reset");
    endtask

    task automatic test_exact();
        run_txn(40, 40, 1);
        n_cmp++;
        if (got_done !== 1'b1 || got_lat != 3 || got_left !== 32'd0) begin
            n_err++;
            $display("FAIL exact_pay: got done=%0b lat=%0d left=%0d want 1/3/0",
                     got_done, got_lat, got_left);
        end
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse: got done=%0b busy=%0b one cycle later, want 0/0", done, busy);
        end
    endtask

    task automatic test_tens();
        run_txn(70, 40, 1);
        n_cmp++;
        if (got_done !== 1'b1 || got_left !== 32'd0) begin
            n_err++;
            $display("FAIL tens_done: got done=%0b left=%0d want 1/0", got_done, got_left);
        end
        n_cmp++;
        if (int'(dut.u_inv.count_q[1]) != 17) begin
            n_err++;
            $display("FAIL tens_count10: got %0d want 17", dut.u_inv.count_q[1]);
        end
    endtask

    task automatic test_mixed();
        run_txn(100, 34, 2);
        n_cmp++;
        if (got_done !== 1'b1 || got_left !== 32'd0) begin
            n_err++;
            $display("FAIL mixed_done: got done=%0b left=%0d want 1/0", got_done, got_left);
        end
        check_counts("mixed");
    endtask

    task automatic test_short();
        do_reset();
        for (int i = 0; i < 5; i++)  run_txn(40, 0, 0);
        for (int i = 0; i < 19; i++) run_txn(5, 0, 0);
        for (int i = 0; i < 4; i++)  run_txn(4, 0, 0);
        run_txn(2, 0, 0);
        check_counts("drain");
        run_txn(40, 20, 1);
        n_cmp++;
        if (got_err !== 1'b1 || got_code !== 2'd2 || got_left !== 32'd13 || exp_left != 13) begin
            n_err++;
            $display("FAIL short: got err=%0b code=%0d left=%0d want 1/2/13", got_err, got_code, got_left);
        end
        clear_err();
    endtask

    task automatic test_jam();
        int k;
        int vc;
        do_reset();
        total_money = 32'd60; cost = 32'd40; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!coin_valid && k < 20) begin tick(); k++; end
        n_cmp++;
        if (coin_valid !== 1'b1 || coin_sel !== 2'd1) begin
            n_err++;
            $display("FAIL jam_offer: got valid=%0b sel=%0d want 1/1", coin_valid, coin_sel);
        end
        vc = 0;
        while (coin_valid && !err && vc < 100) begin tick(); vc++; end
        n_cmp++;
        if (vc != ACK_TO || err !== 1'b1 || err_code !== 2'd3) begin
            n_err++;
            $display("FAIL jam: got valid_cycles=%0d err=%0b code=%0d want %0d/1/3", vc, err, err_code, ACK_TO);
        end
        n_cmp++;
        if (change_left !== 32'd20 || int'(dut.u_inv.count_q[1]) != INIT_CNT || coin_valid !== 1'b0) begin
            n_err++;
            $display("FAIL jam_state: got left=%0d count10=%0d valid=%0b want 20/%0d/0",
                     change_left, dut.u_inv.count_q[1], coin_valid, INIT_CNT);
        end
        clear_err();
    endtask

    task automatic test_reset_mid();
        int k;
        run_txn(70, 40, 1);
        total_money = 32'd60; cost = 32'd40; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!coin_valid && k < 20) begin tick(); k++; end
        n_cmp++;
        if (coin_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_offer: got valid=%0b want 1", coin_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = INIT_CNT;
        n_cmp++;
        if (coin_valid !== 1'b0 || busy !== 1'b0 || change_left !== 32'd0) begin
            n_err++;
            $display("FAIL midreset: got valid=%0b busy=%0b left=%0d want 0/0/0", coin_valid, busy, change_left);
        end
        check_counts("midreset");
    endtask

    task automatic test_underpay_refill();
        run_txn(10, 25, 1);
        n_cmp++;
        if (got_err !== 1'b1 || got_code !== 2'd1 || got_left !== 32'd0) begin
            n_err++;
            $display("FAIL underpay: got err=%0b code=%0d left=%0d want 1/1/0", got_err, got_code, got_left);
        end
        refill = 1'b1; refill_sel = 2'd3; refill_cnt = 8'd20;
        tick();
        refill = 1'b0;
        check_counts("busy_refill");
        clear_err();
        refill = 1'b1; refill_sel = 2'd3; refill_cnt = 8'd230;
        tick();
        refill_cnt = 8'd20;
        tick();
        refill = 1'b0;
        n_cmp++;
        if (dut.u_inv.count_q[3] !== 8'd255) begin
            n_err++;
            $display("FAIL refill_sat: got %0d want 255", dut.u_inv.count_q[3]);
        end
        m_cnt[3] = 255;
        // Refill and start in the same idle cycle both take effect
        refill = 1'b1; refill_sel = 2'd1; refill_cnt = 8'd5;
        m_cnt[1] = m_cnt[1] + 5;
        run_txn(10, 0, 1);
        n_cmp++;
        if (got_done !== 1'b1) begin
            n_err++;
            $display("FAIL refill_start_done: got done=%0b want 1", got_done);
        end
        check_counts("refill_start");
    endtask

    initial begin
        test_reset();
        test_exact();
        test_tens();
        test_mixed();
        test_short();
        test_jam();
        test_reset_mid();
        test_underpay_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
